// File: rtl/control_fsm.sv
// Multi-cycle main control unit for the RV32 datapath.
// Sequences IFETCH -> DECODE -> EXEC -> (MEM) -> (WB) and decodes the live
// opcode into datapath strobes. Strobes are not latched: they follow instr
// combinationally in every state except IFETCH.
module control_fsm (
  input  logic        clk,
  input  logic        rst,       // asynchronous, active-low
  input  logic [31:0] instr,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        RegDst,
  output logic        ALUsrc,
  output logic        branch,
  output logic        jump,
  output logic        memWrite,
  output logic        memRead,
  output logic [1:0]  ALUop
);

  localparam logic [2:0] IFETCH = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Kept as plain "state" so benches can probe it hierarchically.
  logic [2:0] state;
  logic [2:0] state_d;
  logic [6:0] opcode;

  assign opcode = instr[6:0];

  // Upper instruction bits belong to the datapath, not to this block.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[31:7];

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IFETCH;
    else      state <= state_d;
  end

  // Next-state logic; EXEC and MEM branch on the live opcode.
  always_comb begin
    state_d = IFETCH;
    case (state)
      IFETCH: state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_d = MEM;
        else if (opcode == OP_R)                     state_d = WB;
        else                                         state_d = IFETCH;
      end
      MEM:     state_d = (opcode == OP_LOAD) ? WB : IFETCH;
      WB:      state_d = IFETCH;
      default: state_d = IFETCH;  // illegal codes 5-7 recover to fetch
    endcase
  end

  // Output decode; silent in IFETCH and in illegal states.
  always_comb begin
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    RegDst   = 1'b0;
    ALUsrc   = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    memWrite = 1'b0;
    memRead  = 1'b0;
    ALUop    = 2'b00;
    if (state == DECODE || state == EXEC || state == MEM || state == WB) begin
      case (opcode)
        OP_R: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          ALUop    = 2'b10;
        end
        OP_LOAD: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          ALUsrc   = 1'b1;
          memRead  = 1'b1;
        end
        OP_STORE: begin
          ALUsrc   = 1'b1;
          memWrite = 1'b1;
        end
        OP_BR: begin
          branch   = 1'b1;
          ALUop    = 2'b01;
        end
        // Link register write for JAL is handled outside this block.
        OP_JAL:  jump = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed reset / per-class / live-decode / abort
// checks, then randomized instruction streams checked through a scoreboard
// queue filled by the driver and drained by a negedge monitor.
module tb_control_fsm;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        RegWrite, MemToReg, RegDst, ALUsrc, branch, jump, memWrite, memRead;
  logic [1:0]  ALUop;

  int n_tests = 0;
  int n_fail  = 0;

  control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .RegDst(RegDst), .ALUsrc(ALUsrc),
    .branch(branch), .jump(jump), .memWrite(memWrite), .memRead(memRead),
    .ALUop(ALUop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // {RegWrite,MemToReg,RegDst,ALUsrc,branch,jump,memWrite,memRead,ALUop}
  logic [9:0] outs;
  assign outs = {RegWrite, MemToReg, RegDst, ALUsrc, branch, jump, memWrite, memRead, ALUop};

  // Reference decode table, one field at a time.
  function automatic logic [9:0] ref_outs(input logic [6:0] op);
    logic rw, m2r, dst, src, br, j, mw, mr;
    logic [1:0] aop;
    rw = 0; m2r = 0; dst = 0; src = 0; br = 0; j = 0; mw = 0; mr = 0; aop = 2'b00;
    if (op == OP_R)          begin rw = 1; dst = 1; aop = 2'b10; end
    else if (op == OP_LOAD)  begin rw = 1; m2r = 1; src = 1; mr = 1; end
    else if (op == OP_STORE) begin src = 1; mw = 1; end
    else if (op == OP_BR)    begin br = 1; aop = 2'b01; end
    else if (op == OP_JAL)   j = 1;
    return {rw, m2r, dst, src, br, j, mw, mr, aop};
  endfunction

  // Cycles from IFETCH back to IFETCH for each instruction class.
  function automatic int ref_len(input logic [6:0] op);
    if (op == OP_LOAD) return 5;
    if (op == OP_R || op == OP_STORE) return 4;
    return 3;
  endfunction

  // State visited in the i-th cycle of an instruction.
  function automatic logic [2:0] ref_state(input logic [6:0] op, input int i);
    if (i < 3) return 3'(i);
    if (op == OP_LOAD) return 3'(i);   // MEM then WB
    if (op == OP_R) return 3'd4;       // WB
    return 3'd3;                       // store: MEM
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input logic [2:0] t);
    int n = 0;
    while (dut.state !== t && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(dut.state), 32'(t));
  endtask

  // Scoreboard: driver pushes {state, outs} per cycle, monitor pops at negedge.
  logic [12:0] exp_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("seq_state", 32'(dut.state), 32'(e[12:10]));
        check("seq_outs",  32'(outs),      32'(e[9:0]));
      end
    end
  end

  task automatic run_instr(input logic [31:0] w);
    int len;
    len = ref_len(w[6:0]);
    for (int i = 0; i < len; i++) begin
      logic [2:0] s;
      s = ref_state(w[6:0], i);
      instr = w;
      exp_q.push_back({s, (s == 3'd0) ? 10'd0 : ref_outs(w[6:0])});
      step();
    end
  endtask

  initial begin
    rst   = 1'b0;
    instr = 32'h0;
    // Reset held for two cycles
    step(); step();
    check("rst_state", 32'(dut.state), 32'd0);
    check("rst_outs",  32'(outs), 32'd0);
    @(negedge clk); rst = 1'b1;
    step();
    check("rel_decode", 32'(dut.state), 32'd1);
    step();
    check("rel_exec", 32'(dut.state), 32'd2);
    step();
    check("unk_to_fetch", 32'(dut.state), 32'd0);

    // R-type
    instr = 32'h002081B3;
    wait_state("r_wait_exec", 3'd2);
    check("r_outs", 32'(outs), 32'(10'b1010000010));
    step(); check("r_wb", 32'(dut.state), 32'd4);
    step(); check("r_fetch", 32'(dut.state), 32'd0);

    // Load
    instr = 32'h0040A103;
    wait_state("ld_wait_exec", 3'd2);
    check("ld_outs", 32'(outs), 32'(10'b1101000100));
    step(); check("ld_mem", 32'(dut.state), 32'd3);
    step(); check("ld_wb", 32'(dut.state), 32'd4);
    step(); check("ld_fetch", 32'(dut.state), 32'd0);

    // Store
    instr = 32'h0020A1A3;
    wait_state("st_wait_exec", 3'd2);
    check("st_outs", 32'(outs), 32'(10'b0001001000));
    step(); check("st_mem", 32'(dut.state), 32'd3);
    step(); check("st_fetch", 32'(dut.state), 32'd0);

    // Branch, then JAL
    instr = 32'h002081E3;
    wait_state("br_wait_exec", 3'd2);
    check("br_outs", 32'(outs), 32'(10'b0000100001));
    step(); check("br_fetch", 32'(dut.state), 32'd0);
    instr = 32'h000030EF;
    wait_state("jal_wait_exec", 3'd2);
    check("jal_outs", 32'(outs), 32'(10'b0000010000));
    step(); check("jal_fetch", 32'(dut.state), 32'd0);

    // All-ones and all-zero words decode to nothing
    instr = 32'hFFFFFFFF;
    wait_state("ones_wait_exec", 3'd2);
    check("ones_outs", 32'(outs), 32'd0);
    step(); check("ones_fetch", 32'(dut.state), 32'd0);

    // Live decode: R-type turns into load mid-EXEC
    instr = 32'h002081B3;
    wait_state("live_wait_exec", 3'd2);
    check("live_r_outs", 32'(outs), 32'(10'b1010000010));
    #2 instr = 32'h0040A103;
    #1 check("live_ld_outs", 32'(outs), 32'(10'b1101000100));
    step(); check("live_mem", 32'(dut.state), 32'd3);
    // Abort in MEM without a clock edge
    #2 rst = 1'b0;
    #1 check("abort_state", 32'(dut.state), 32'd0);
    check("abort_outs", 32'(outs), 32'd0);
    @(negedge clk); rst = 1'b1;
    step(); check("abort_restart", 32'(dut.state), 32'd1);
    wait_state("rand_sync", 3'd0);

    // Randomized instruction stream
    for (int k = 0; k < 200; k++) begin
      logic [31:0] w;
      logic [6:0]  op;
      w = $urandom;
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_LOAD;
        2: op = OP_STORE;
        3: op = OP_BR;
        4: op = OP_JAL;
        default: op = 7'($urandom);
      endcase
      w[6:0] = op;
      run_instr(w);
    end
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multi-cycle main control unit for the RV32 datapath. It sequences each instruction through IFETCH, DECODE, EXEC, MEM and WB. It decodes the 7-bit opcode of the current instruction word into datapath control strobes (register write, mem-to-reg select, destination select, ALU source, branch, jump, memory read/write, ALU op class). It sits between the instruction register and the datapath muxes, register file and data memory.

Parameters:
- none. State encodings are fixed localparams: IFETCH=3'd0, DECODE=3'd1, EXEC=3'd2, MEM=3'd3, WB=3'd4.

Ports:
- clk  input  1  system clock; state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr  input  32  current instruction word; only instr[6:0] (opcode) is used.
- RegWrite  output  1  register file write enable.
- MemToReg  output  1  writeback data select: 1 = memory, 0 = ALU.
- RegDst  output  1  destination select: 1 for R-type.
- ALUsrc  output  1  ALU operand B select: 1 = immediate, 0 = rs2.
- branch  output  1  conditional branch instruction.
- jump  output  1  JAL instruction.
- memWrite  output  1  data memory write strobe.
- memRead  output  1  data memory read strobe.
- ALUop  output  2  ALU class: 00 = add (address/jump), 01 = compare (branch), 10 = funct-decoded (R-type).

Behaviour:
- The state register is 3 bits and internally named `state`, so benches can probe it hierarchically.
- Reset:
  - rst low forces state to IFETCH immediately (asynchronous).
  - All outputs are 0 while in reset and while in IFETCH.
  - Reset asserted mid-instruction aborts the instruction; no strobe survives past the reset assertion.
- Transitions (one per rising clk, rst high):
  - IFETCH -> DECODE.
  - DECODE -> EXEC.
  - EXEC -> MEM for load (0000011) or store (0100011).
  - EXEC -> WB for R-type (0110011).
  - EXEC -> IFETCH for branch, JAL or any unrecognised opcode.
  - MEM -> WB for load; MEM -> IFETCH for store.
  - WB -> IFETCH.
  - Any illegal state code (5-7) -> IFETCH.
- Cycle counts from IFETCH back to IFETCH: R-type 4, load 5, store 4, branch/JAL 3.
- Outputs in DECODE, EXEC, MEM and WB are a purely combinational decode of instr[6:0]. They are not latched.
  - A change on instr while in those states is reflected in the outputs in the same time step.
  - The next-state decision in EXEC and MEM also uses the live opcode.
- Decode table (every signal not listed is 0):
  - 0110011 R-type: RegWrite=1, RegDst=1, ALUop=10.
  - 0000011 load: RegWrite=1, MemToReg=1, ALUsrc=1, memRead=1, ALUop=00.
  - 0100011 store: ALUsrc=1, memWrite=1, ALUop=00.
  - 1100011 branch: branch=1, ALUop=01.
  - 1101111 JAL: jump=1, ALUop=00. RegWrite is 0; link write is not handled by this block.
  - Any other opcode: all outputs 0, ALUop=00.
- instr[31:7] has no effect on any output or transition.
- No X may appear on outputs for any opcode, including all-zero or all-ones words.

Test Plan:
- Reset: hold rst=0 with instr=0x00000000 for 2 cycles -> state=0, all outputs 0. Release rst -> state reaches DECODE, then EXEC, on successive rising edges.
- R-type: instr=0x002081B3, wait for state=EXEC -> RegWrite=1, RegDst=1, ALUop=10, all others 0. Next states WB, then IFETCH.
- Load: instr=0x0040A103 in EXEC -> RegWrite=1, MemToReg=1, ALUsrc=1, memRead=1, ALUop=00, others 0. Sequence EXEC, MEM, WB, IFETCH.
- Store: instr=0x0020A1A3 in EXEC -> ALUsrc=1, memWrite=1, ALUop=00, others 0. Sequence EXEC, MEM, IFETCH.
- Branch then JAL:
  - instr=0x002081E3 in EXEC -> branch=1, ALUop=01, others 0.
  - instr=0x000030EF in EXEC -> jump=1, ALUop=00, others 0.
  - Both return to IFETCH one cycle after EXEC.
- Live decode and abort:
  - Change instr from R-type to load while state=EXEC -> outputs switch to load values in the same time step.
  - Drive rst=0 during MEM -> state=0 and all outputs 0 immediately, without waiting for a clock edge.
